// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the iterative RV32M unit
//   master (datapath): drives start_i, op_i, a_i, b_i; observes busy_o, done_o, result_o
//   slave  (muldiv_unit): the reverse
interface muldiv_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  modport master (output start_i, op_i, a_i, b_i, input busy_o, done_o, result_o);
  modport slave (input start_i, op_i, a_i, b_i, output busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 32 radix-2 steps, one-cycle done pulse
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : muldiv_unit_if.slave (start_i/op_i/a_i/b_i in, busy_o/done_o/result_o out)
//   MULDIV_FAST_SPECIAL_EN : when defined, divide-by-zero and signed overflow finish without CALC
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [4:0]       count_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [W-1:0]     m_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     result_q;
  logic             busy_q;
  logic             done_q;
  logic             sa, sb, dz, neg;
  logic [W-1:0]     am, bm;
  logic [W:0]       msum, shl, dif;
  logic             ge;
  logic [2*W-1:0]   mul_d, div_d, acc_d, prod;
  logic [W-1:0]     quo, rem, result_d;
  // Signed interpretation per funct3: MULH/DIV/REM both, MULHSU only rs1.
  always_comb begin
    sa = bus.a_i[W-1] & (bus.op_i == 3'b001 || bus.op_i == 3'b010 || bus.op_i == 3'b100 || bus.op_i == 3'b110);
    sb = bus.b_i[W-1] & (bus.op_i == 3'b001 || bus.op_i == 3'b100 || bus.op_i == 3'b110);
    am = sa ? -bus.a_i : bus.a_i;
    bm = sb ? -bus.b_i : bus.b_i;
    dz = ~|bus.b_i;
    // Quotient of a divide by zero must stay all-ones, so its sign is suppressed.
    neg = bus.op_i[2] ? (bus.op_i[1] ? sa : (sa ^ sb) & ~dz) : (sa ^ sb);
  end
  // acc_q holds {hi, lo}: multiply shifts the multiplier out of lo while adding into hi;
  // divide shifts the dividend out of lo into the partial remainder in hi and quotient bits into lo.
  always_comb begin
    msum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_d = {msum, acc_q[W-1:1]};
    shl = {acc_q[2*W-1:W], acc_q[W-1]};
    dif = shl - {1'b0, m_q};
    ge = ~dif[W];
    div_d = {ge ? dif[W-1:0] : shl[W-1:0], acc_q[W-2:0], ge};
    acc_d = op_q[2] ? div_d : mul_d;
    prod = neg_q ? -acc_d : acc_d;
    quo = neg_q ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem = neg_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
    result_d = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
  end
`ifdef MULDIV_FAST_SPECIAL_EN
  logic         special;
  logic [W-1:0] spec_res;
  always_comb begin
    special = bus.op_i[2] & (dz | (~bus.op_i[0] & (bus.a_i == {1'b1, {(W-1){1'b0}}}) & (&bus.b_i)));
    spec_res = dz ? (bus.op_i[1] ? bus.a_i : '1) : (bus.op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}});
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          op_q    <= bus.op_i;
          neg_q   <= neg;
          m_q     <= bus.op_i[2] ? bm : am;
          acc_q   <= {{W{1'b0}}, bus.op_i[2] ? am : bm};
          count_q <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (special) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= spec_res;
          end else begin
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
`else
          state_q <= CALC;
          busy_q  <= 1'b1;
`endif
        end
        CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule
